// File: rtl/regfile_wb_scheduler.sv
// Write-port owner for the 32x32 register file: round-robin write-back arbitration
// between ALU (port 0) and load (port 1) results, plus an r1..r(NREG-1) clear sequencer.
module regfile_wb_scheduler #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NREG = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb0_valid,
    input  logic [AW-1:0] wb0_addr,
    input  logic [DW-1:0] wb0_data,
    output logic          wb0_ready,
    input  logic          wb1_valid,
    input  logic [AW-1:0] wb1_addr,
    input  logic [DW-1:0] wb1_data,
    output logic          wb1_ready,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata
);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(NREG - 1);
    localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state, state_d;
    logic          rr_ptr, rr_ptr_d;
    logic [AW-1:0] clr_cnt, clr_cnt_d;
    logic [AW-1:0] clr_cnt_inc;
    logic          rf_we_d;
    logic [AW-1:0] rf_addr_d;
    logic [DW-1:0] rf_wdata_d;
    logic          clr_busy_d;
    logic          clr_done_d;
    logic          accept;
    logic          grant0;
    logic          grant1;

    // Arbitration: a pending clear start or reset blocks both requesters.
    always_comb begin
        accept    = !reset && (state == IDLE) && !clr_start;
        grant0    = wb0_valid && (!wb1_valid || !rr_ptr);
        grant1    = wb1_valid && (!wb0_valid || rr_ptr);
        wb0_ready = accept && grant0;
        wb1_ready = accept && grant1;
    end

    assign clr_cnt_inc = clr_cnt + AW'(1);

    // clr_cnt tracks the clear address currently on rf_addr, so it never reaches r0.
    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        clr_cnt_d  = clr_cnt;
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr;
        rf_wdata_d = rf_wdata;
        clr_busy_d = 1'b0;
        clr_done_d = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_d    = CLEAR;
                    rf_we_d    = 1'b1;
                    rf_addr_d  = clr_cnt;
                    rf_wdata_d = '0;
                    clr_busy_d = 1'b1;
                    clr_done_d = (clr_cnt == LAST_ADDR);
                end else if (wb0_ready) begin
                    rf_we_d    = (wb0_addr != '0);
                    rf_addr_d  = wb0_addr;
                    rf_wdata_d = wb0_data;
                    rr_ptr_d   = 1'b1;
                end else if (wb1_ready) begin
                    rf_we_d    = (wb1_addr != '0);
                    rf_addr_d  = wb1_addr;
                    rf_wdata_d = wb1_data;
                    rr_ptr_d   = 1'b0;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_d   = IDLE;
                    clr_cnt_d = FIRST_ADDR;
                end else begin
                    clr_cnt_d  = clr_cnt_inc;
                    rf_we_d    = 1'b1;
                    rf_addr_d  = clr_cnt_inc;
                    rf_wdata_d = '0;
                    clr_busy_d = 1'b1;
                    clr_done_d = (clr_cnt_inc == LAST_ADDR);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            clr_cnt  <= FIRST_ADDR;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            clr_cnt  <= clr_cnt_d;
            rf_we    <= rf_we_d;
            rf_addr  <= rf_addr_d;
            rf_wdata <= rf_wdata_d;
            clr_busy <= clr_busy_d;
            clr_done <= clr_done_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then random traffic, all checked
// against a transaction-level model of grants, clear sweeps and write-back results.
module tb_regfile_wb_scheduler;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wb0_valid = 1'b0;
    logic [AW-1:0] wb0_addr = '0;
    logic [DW-1:0] wb0_data = '0;
    logic          wb0_ready;
    logic          wb1_valid = 1'b0;
    logic [AW-1:0] wb1_addr = '0;
    logic [DW-1:0] wb1_data = '0;
    logic          wb1_ready;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          clr_done;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;

    regfile_wb_scheduler #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb0_valid (wb0_valid),
        .wb0_addr  (wb0_addr),
        .wb0_data  (wb0_data),
        .wb0_ready (wb0_ready),
        .wb1_valid (wb1_valid),
        .wb1_addr  (wb1_addr),
        .wb1_data  (wb1_data),
        .wb1_ready (wb1_ready),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: clear sweep position, fairness pointer, expected outputs.
    bit            m_clearing;
    int            m_pos;
    bit            m_rr;
    int            m_win;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_busy;
    logic          m_done;
    int            wr_cnt;
    int            done_cnt;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clearing = 0;
        m_pos      = 1;
        m_rr       = 0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_busy     = 1'b0;
        m_done     = 1'b0;
    endtask

    // Called at a negedge; asserts reset mid-cycle and checks the immediate effect.
    task automatic do_reset();
        reset     = 1'b1;
        wb0_valid = 1'b1;
        wb1_valid = 1'b1;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_addr", rf_addr, '0);
        chk("rst_rf_wdata", rf_wdata, '0);
        chk("rst_clr_busy", clr_busy, 1'b0);
        chk("rst_clr_done", clr_done, 1'b0);
        chk("rst_wb0_ready", wb0_ready, 1'b0);
        chk("rst_wb1_ready", wb1_ready, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

    // One clock: drive inputs, check readys, predict, then check registered outputs.
    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic cs);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
        clr_start = cs;
        #1;
        m_win = -1;
        if (!m_clearing && !cs) begin
            if (v0 && v1)  m_win = m_rr ? 1 : 0;
            else if (v0)   m_win = 0;
            else if (v1)   m_win = 1;
        end
        chk("wb0_ready", wb0_ready, logic'(m_win == 0));
        chk("wb1_ready", wb1_ready, logic'(m_win == 1));
        m_done = 1'b0;
        if (m_clearing) begin
            if (m_pos == NREG - 1) begin
                m_clearing = 0;
                m_pos      = 1;
                m_we       = 1'b0;
                m_busy     = 1'b0;
            end else begin
                m_pos   = m_pos + 1;
                m_we    = 1'b1;
                m_addr  = AW'(m_pos);
                m_wdata = '0;
                m_busy  = 1'b1;
                m_done  = logic'(m_pos == NREG - 1);
            end
        end else if (cs) begin
            m_clearing = 1;
            m_pos      = 1;
            m_we       = 1'b1;
            m_addr     = AW'(1);
            m_wdata    = '0;
            m_busy     = 1'b1;
            m_done     = logic'(NREG == 2);
        end else begin
            m_busy = 1'b0;
            m_we   = 1'b0;
            if (m_win >= 0) begin
                m_addr  = (m_win == 0) ? a0 : a1;
                m_wdata = (m_win == 0) ? d0 : d1;
                m_we    = logic'(m_addr != 0);
                m_rr    = (m_win == 0);
            end
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, m_we);
        chk("rf_addr", rf_addr, m_addr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("clr_busy", clr_busy, m_busy);
        chk("clr_done", clr_done, m_done);
        if (rf_we === 1'b1)    wr_cnt++;
        if (clr_done === 1'b1) done_cnt++;
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int iter;
        bit granted;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single ALU write, then quiet cycle.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
        idle_step();

        // Both valid from rr_ptr=0: grants alternate p0,p1,p0,p1.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd3, 32'h3333_0000 + DW'(i), 1'b1, 5'd4, 32'h4444_0000 + DW'(i), 1'b0);
            chk("t2_grant_seq", DW'(m_win), DW'(i % 2));
        end
        idle_step();

        // Write to r0 is accepted but suppressed.
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0);
        idle_step();

        // clr_start beats a pending request; requester holds until granted after the sweep.
        step(1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, '0, '0, 1'b1);
        granted = 0;
        iter = 0;
        while (!granted && iter < 40) begin
            iter++;
            step(1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, '0, '0, 1'b0);
            granted = (m_win == 0);
        end
        chk("t4_granted", DW'(granted), DW'(1));
        chk("t4_grant_cycle", DW'(iter), DW'(NREG));
        idle_step();

        // Reset while rf_addr=10 abandons the sweep; next sweep restarts at r1.
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 9; i++) idle_step();
        chk("t5_addr_before_reset", rf_addr, AW'(10));
        do_reset();
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) idle_step();
        chk("t5_no_writes_after_reset", DW'(wr_cnt), DW'(0));
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        chk("t5_restart_addr", rf_addr, AW'(1));
        for (int i = 0; i < NREG; i++) idle_step();

        // Repeated clr_start during a sweep is ignored.
        wr_cnt   = 0;
        done_cnt = 0;
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < NREG - 1; i++)
            step(1'b0, '0, '0, 1'b0, '0, '0, logic'($urandom_range(0, 2) == 0));
        for (int i = 0; i < 3; i++) idle_step();
        chk("t6_write_count", DW'(wr_cnt), DW'(NREG - 1));
        chk("t6_done_count", DW'(done_cnt), DW'(1));

        // Random traffic, occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(logic'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), DW'($urandom),
                     logic'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), DW'($urandom),
                     logic'($urandom_range(0, 49) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
